// File: rtl/sys_bus_if.sv
// sys_bus_if
//   Single-request system bus. One request at a time is described by addr,
//   wdata, wen and ren. The responder answers with a one-cycle ack pulse,
//   which carries rdata and err.
//   Parameters : AW address width, DW data width
//   Modport m  : requester side (drives addr/wdata/wen/ren, samples rdata/ack/err)
//   Modport s  : responder side (samples addr/wdata/wen/ren, drives rdata/ack/err)
interface sys_bus_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          wen;
  logic          ren;
  logic [DW-1:0] rdata;
  logic          ack;
  logic          err;

  modport m (output addr, wdata, wen, ren, input rdata, ack, err);
  modport s (input addr, wdata, wen, ren, output rdata, ack, err);
endinterface

// File: rtl/sys_bus_decoder.sv
// sys_bus_decoder
//   Splits one upstream system-bus port into SN slave ports by address.
//   The slave index is addr[SW +: clog2(SN)]. The slave sees addr[SW-1:0],
//   zero-extended. The block forwards one request at a time as a registered
//   one-cycle strobe, then returns the selected slave's ack/err/rdata one
//   cycle later. It answers unmapped indices itself with ack+err.
//   Ports:
//     ACLK     clock
//     ARESETn  asynchronous active-low reset
//     bus      upstream port (sys_bus_if.s)
//     bus_m    SN downstream slave ports (sys_bus_if.m)
//   Optional feature: define SYS_BUS_DECODER_TIMEOUT_EN to add a 16-cycle
//   slave timeout. On timeout the block answers ack+err with rdata 0xDEADBEEF.
//   Without the macro, the block waits for the slave indefinitely.
module sys_bus_decoder #(
  parameter int SN = 8,
  parameter int SW = 20,
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic  ACLK,
  input  logic  ARESETn,
  sys_bus_if.s  bus,
  sys_bus_if.m  bus_m [SN]
);

  localparam int            IW        = $clog2(SN);
  localparam int            SELW      = (IW > 0) ? IW : 1;
  localparam logic [DW-1:0] TMO_RDATA = DW'(32'hDEAD_BEEF);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            is_wr_q, is_wr_d;
  logic [SN-1:0]   m_wen_q, m_wen_d;
  logic [SN-1:0]   m_ren_q, m_ren_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;
  logic [DW-1:0]   rdata_q, rdata_d;

  logic [SN-1:0]   m_ack_s;
  logic [SN-1:0]   m_err_s;
  logic [DW-1:0]   m_rdata_s [SN];

  logic [AW-1:0]   idx_full_s;
  logic [SELW-1:0] req_sel_s;
  logic            req_mapped_s;
  logic [AW-1:0]   req_off_s;
  logic [SN-1:0]   req_onehot_s;

  logic            sel_ack_s;
  logic            sel_err_s;
  logic [DW-1:0]   sel_rdata_s;
  logic            tmo_fire_s;

  // Fan the latched request out to every port; only the strobes differ per port.
  for (genvar g = 0; g < SN; g++) begin : g_port
    assign bus_m[g].addr  = addr_q;
    assign bus_m[g].wdata = wdata_q;
    assign bus_m[g].wen   = m_wen_q[g];
    assign bus_m[g].ren   = m_ren_q[g];
    assign m_ack_s[g]     = bus_m[g].ack;
    assign m_err_s[g]     = bus_m[g].err;
    assign m_rdata_s[g]   = bus_m[g].rdata;
  end

  assign bus.ack   = ack_q;
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;

  // Decode the upstream address into a slave index, a window offset and a one-hot port select.
  always_comb begin
    idx_full_s = bus.addr >> SW;
    if (IW > 0) begin
      req_sel_s = idx_full_s[SELW-1:0];
    end else begin
      // A single slave owns the whole space, so there are no index bits.
      req_sel_s = '0;
    end
    req_mapped_s = (int'(req_sel_s) < SN);
    req_off_s    = bus.addr & ((AW'(1) << SW) - AW'(1));
    req_onehot_s = SN'(1) << req_sel_s;
  end

  // Pick the response of the latched slave. Responses from other ports are masked out.
  always_comb begin
    sel_ack_s   = 1'b0;
    sel_err_s   = 1'b0;
    sel_rdata_s = '0;
    for (int i = 0; i < SN; i++) begin
      sel_ack_s   = sel_ack_s   | (m_ack_s[i] & (sel_q == SELW'(i)));
      sel_err_s   = sel_err_s   | (m_err_s[i] & (sel_q == SELW'(i)));
      sel_rdata_s = sel_rdata_s | (m_rdata_s[i] & {DW{sel_q == SELW'(i)}});
    end
  end

`ifdef SYS_BUS_DECODER_TIMEOUT_EN
  logic [4:0] tmo_cnt_q, tmo_cnt_d;
  logic       strobe_issue_s;

  // Timeout counter: restarts when a slave strobe is issued and advances once per PEND cycle.
  always_comb begin
    strobe_issue_s = (state_q == ST_IDLE) && (bus.wen | bus.ren) && req_mapped_s;
    if (strobe_issue_s) begin
      tmo_cnt_d = 5'd0;
    end else if (state_q == ST_PEND) begin
      tmo_cnt_d = tmo_cnt_q + 5'd1;
    end else begin
      tmo_cnt_d = tmo_cnt_q;
    end
  end

  // The count reaches 16 on the edge that leaves a PEND cycle holding 15.
  // A slave ack in that same cycle still takes priority in the FSM.
  assign tmo_fire_s = (state_q == ST_PEND) && (tmo_cnt_q == 5'd15);

  // Timeout counter register.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      tmo_cnt_q <= 5'd0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  assign tmo_fire_s = 1'b0;
`endif

  // FSM next state: accept a request in IDLE, wait for the selected slave in PEND.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    is_wr_d = is_wr_q;
    m_wen_d = '0;
    m_ren_d = '0;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.wen | bus.ren) begin
          sel_d   = req_sel_s;
          addr_d  = req_off_s;
          wdata_d = bus.wdata;
          // A simultaneous read and write is treated as the write alone.
          is_wr_d = bus.wen;
          if (req_mapped_s) begin
            m_wen_d = bus.wen ? req_onehot_s : '0;
            m_ren_d = bus.wen ? '0 : req_onehot_s;
            state_d = ST_PEND;
          end else begin
            // Unmapped index: answer locally so the upstream port never stalls.
            ack_d   = 1'b1;
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PEND: begin
        // Requests arriving here are dropped on purpose: no strobe and no ack.
        if (sel_ack_s) begin
          ack_d   = 1'b1;
          err_d   = sel_err_s;
          rdata_d = is_wr_q ? '0 : sel_rdata_s;
          state_d = ST_IDLE;
        end else if (tmo_fire_s) begin
          ack_d   = 1'b1;
          err_d   = 1'b1;
          rdata_d = TMO_RDATA;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_PEND;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset clears every output immediately.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      is_wr_q <= 1'b0;
      m_wen_q <= '0;
      m_ren_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      is_wr_q <= is_wr_d;
      m_wen_q <= m_wen_d;
      m_ren_q <= m_ren_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_sys_bus_decoder.sv
// tb_sys_bus_decoder
//   Testbench for sys_bus_decoder with SN=5, so slave indices 5..7 are unmapped.
//   It applies a table of directed vectors, then runs randomized transactions
//   against a transaction-level reference model. It also runs hand-written
//   sequences for reset, back-to-back requests and late acks.
module tb_sys_bus_decoder;
  localparam int SN = 5;
  localparam int SW = 20;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef SYS_BUS_DECODER_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic ACLK    = 1'b0;
  logic ARESETn = 1'b0;
  always #5 ACLK = ~ACLK;

  sys_bus_if #(.AW(AW), .DW(DW)) up_if ();
  sys_bus_if #(.AW(AW), .DW(DW)) m_if [SN] ();

  sys_bus_decoder #(.SN(SN), .SW(SW), .AW(AW), .DW(DW)) dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .bus     (up_if),
    .bus_m   (m_if)
  );

  logic [SN-1:0] m_wen, m_ren, s_ack, s_err;
  logic [AW-1:0] m_addr  [SN];
  logic [DW-1:0] m_wdata [SN];
  logic [DW-1:0] s_rdata [SN];

  for (genvar g = 0; g < SN; g++) begin : g_slv
    assign m_wen[g]       = m_if[g].wen;
    assign m_ren[g]       = m_if[g].ren;
    assign m_addr[g]      = m_if[g].addr;
    assign m_wdata[g]     = m_if[g].wdata;
    assign m_if[g].ack    = s_ack[g];
    assign m_if[g].err    = s_err[g];
    assign m_if[g].rdata  = s_rdata[g];
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wen;
    logic        ren;
    int          k;          // cycle of the slave ack, -1 = never
    logic [31:0] srd;
    logic        serr;
    bit          noise;      // requests in PEND + spurious/late acks
    int          e_ack_cyc;  // -1 = no upstream ack expected
    logic        e_err;
    logic [31:0] e_rd;
    int          e_port;     // -1 = no strobe expected
    logic        e_wr;
    logic [31:0] e_maddr;
    logic [31:0] e_wdata;
  } vec_t;

  typedef struct {
    int          ack_cyc;
    int          ack_cnt;
    logic [31:0] rd;
    logic        er;
    int          st_cyc;
    int          st_port;
    int          st_cnt;
    logic        st_wr;
    logic [31:0] st_addr;
    logic [31:0] st_wdata;
    logic [31:0] rd_end;
  } obs_t;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] addr, input logic [31:0] wdata,
                              input logic wen, input logic ren, input int k,
                              input logic [31:0] srd, input logic serr, input bit noise,
                              input int e_ack, input logic e_err, input logic [31:0] e_rd,
                              input int e_port, input logic e_wr, input logic [31:0] e_maddr);
    vec_t v;
    v.addr = addr; v.wdata = wdata; v.wen = wen; v.ren = ren; v.k = k;
    v.srd = srd; v.serr = serr; v.noise = noise;
    v.e_ack_cyc = e_ack; v.e_err = e_err; v.e_rd = e_rd;
    v.e_port = e_port; v.e_wr = e_wr; v.e_maddr = e_maddr; v.e_wdata = wdata;
    return v;
  endfunction

  // Reference model: the expected response of one transaction, from the address map and slave timing.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int   idx;
    r   = v;
    idx = int'((v.addr / (32'd1 << SW)) % 32'd8);
    r.e_wdata = v.wdata;
    if (idx >= SN) begin
      r.e_port = -1; r.e_wr = 1'b0; r.e_maddr = 32'd0;
      r.e_ack_cyc = 1; r.e_err = 1'b1; r.e_rd = 32'd0;
    end else begin
      r.e_port  = idx;
      r.e_wr    = v.wen;
      r.e_maddr = v.addr % (32'd1 << SW);
      if (TMO_EN && (v.k < 0 || v.k > 16)) begin
        r.e_ack_cyc = 17; r.e_err = 1'b1; r.e_rd = 32'hDEAD_BEEF;
      end else begin
        r.e_ack_cyc = (v.k < 0) ? -1 : v.k + 1;
        r.e_err     = v.serr;
        r.e_rd      = v.wen ? 32'd0 : v.srd;
      end
    end
    return r;
  endfunction

  task automatic drive_idle();
    up_if.addr  = 32'd0;
    up_if.wdata = 32'd0;
    up_if.wen   = 1'b0;
    up_if.ren   = 1'b0;
  endtask

  // One transaction: request in cycle 0, then observe for a fixed window. The slave acks on the strobed port in cycle k.
  task automatic run_txn(input vec_t v, output obs_t o);
    int win, pend_end, other;
    o.ack_cyc = -1; o.ack_cnt = 0; o.rd = 32'd0; o.er = 1'b0;
    o.st_cyc = -1; o.st_port = -1; o.st_cnt = 0; o.st_wr = 1'b0;
    o.st_addr = 32'd0; o.st_wdata = 32'd0; o.rd_end = 32'd0;
    win = ((v.k > 17) ? v.k : 17) + 4;
    pend_end = (TMO_EN && (v.k < 0 || v.k > 16)) ? 16 : v.k;
    up_if.addr = v.addr; up_if.wdata = v.wdata; up_if.wen = v.wen; up_if.ren = v.ren;
    for (int c = 1; c <= win; c++) begin
      @(posedge ACLK); #1;
      o.st_cnt += $countones(m_wen) + $countones(m_ren);
      for (int i = 0; i < SN; i++) begin
        if ((m_wen[i] | m_ren[i]) && o.st_port < 0) begin
          o.st_port = i; o.st_cyc = c; o.st_wr = m_wen[i];
          o.st_addr = m_addr[i]; o.st_wdata = m_wdata[i];
        end
      end
      if (up_if.ack) begin
        o.ack_cnt++;
        if (o.ack_cyc < 0) begin
          o.ack_cyc = c; o.rd = up_if.rdata; o.er = up_if.err;
        end
      end
      drive_idle();
      s_ack = '0;
      if (o.st_port >= 0) begin
        other = (o.st_port + 1) % SN;
        if (v.noise && c <= pend_end) begin
          up_if.addr = $urandom; up_if.wdata = $urandom;
          up_if.wen = 1'($urandom_range(0, 1)); up_if.ren = 1'b1;
        end
        if (v.noise && c == 1) begin
          s_ack[other] = 1'b1; s_err[other] = 1'b1; s_rdata[other] = $urandom;
        end
        if (c == v.k || (v.noise && c == v.k + 2)) begin
          s_ack[o.st_port] = 1'b1; s_rdata[o.st_port] = v.srd; s_err[o.st_port] = v.serr;
        end
      end
    end
    o.rd_end = up_if.rdata;
    drive_idle();
    s_ack = '0;
  endtask

  task automatic check_txn(input string tag, input vec_t v, input obs_t o);
    chk({tag, ".ack_cyc"}, o.ack_cyc, v.e_ack_cyc);
    chk({tag, ".ack_cnt"}, o.ack_cnt, (v.e_ack_cyc < 0) ? 0 : 1);
    if (v.e_ack_cyc >= 0) begin
      chk({tag, ".rdata"}, o.rd, v.e_rd);
      chk({tag, ".err"}, o.er, v.e_err);
      chk({tag, ".rdata_hold"}, o.rd_end, v.e_rd);
    end
    chk({tag, ".strobe_cnt"}, o.st_cnt, (v.e_port < 0) ? 0 : 1);
    if (v.e_port >= 0) begin
      chk({tag, ".strobe_port"}, o.st_port, v.e_port);
      chk({tag, ".strobe_cyc"}, o.st_cyc, 1);
      chk({tag, ".strobe_wr"}, o.st_wr, v.e_wr);
      chk({tag, ".m_addr"}, o.st_addr, v.e_maddr);
      chk({tag, ".m_wdata"}, o.st_wdata, v.e_wdata);
    end
  endtask

  initial begin
    vec_t tbl[$];
    vec_t v;
    obs_t o;
    int   op, acks, strobes;
    logic [31:0] addr_or;

    drive_idle();
    s_ack = '0;
    s_err = '0;
    for (int i = 0; i < SN; i++) s_rdata[i] = 32'd0;

    // Expected values are hand-derived from the address map (SN=5, SW=20).
    tbl.push_back(mk(32'h0020_0104, 32'h0, 1'b0, 1'b1, 3, 32'h1234_5678, 1'b0, 1'b0,
                     4, 1'b0, 32'h1234_5678, 2, 1'b0, 32'h0000_0104));
    tbl.push_back(mk(32'h0060_0000, 32'h0, 1'b0, 1'b1, 2, 32'hFFFF_FFFF, 1'b0, 1'b0,
                     1, 1'b1, 32'h0, -1, 1'b0, 32'h0));
    tbl.push_back(mk(32'h0040_0010, 32'hCAFE_0001, 1'b1, 1'b0, 1, 32'h5A5A_5A5A, 1'b0, 1'b0,
                     2, 1'b0, 32'h0, 4, 1'b1, 32'h0000_0010));
    tbl.push_back(mk(32'h0000_0008, 32'h0000_00AB, 1'b1, 1'b1, 2, 32'h5555_5555, 1'b0, 1'b0,
                     3, 1'b0, 32'h0, 0, 1'b1, 32'h0000_0008));
    tbl.push_back(mk(32'h0010_0000, 32'h0, 1'b0, 1'b1, 5, 32'hAAAA_0000, 1'b1, 1'b1,
                     6, 1'b1, 32'hAAAA_0000, 1, 1'b0, 32'h0));
    tbl.push_back(mk(32'h0050_0000, 32'h1, 1'b1, 1'b0, 1, 32'h0, 1'b0, 1'b0,
                     1, 1'b1, 32'h0, -1, 1'b0, 32'h0));
    tbl.push_back(mk(32'h3010_0ABC, 32'h0, 1'b0, 1'b1, 1, 32'h0000_0001, 1'b0, 1'b0,
                     2, 1'b0, 32'h0000_0001, 1, 1'b0, 32'h0000_0ABC));
    tbl.push_back(mk(32'h004F_FFFF, 32'h0, 1'b0, 1'b1, 2, 32'h8765_4321, 1'b0, 1'b0,
                     3, 1'b0, 32'h8765_4321, 4, 1'b0, 32'h000F_FFFF));
`ifdef SYS_BUS_DECODER_TIMEOUT_EN
    tbl.push_back(mk(32'h0020_0200, 32'h0, 1'b0, 1'b1, -1, 32'h0, 1'b0, 1'b0,
                     17, 1'b1, 32'hDEAD_BEEF, 2, 1'b0, 32'h0000_0200));
    tbl.push_back(mk(32'h0030_0300, 32'h0, 1'b0, 1'b1, 16, 32'h0BAD_F00D, 1'b0, 1'b0,
                     17, 1'b0, 32'h0BAD_F00D, 3, 1'b0, 32'h0000_0300));
`else
    tbl.push_back(mk(32'h0030_0300, 32'h0, 1'b0, 1'b1, 30, 32'h0BAD_F00D, 1'b0, 1'b0,
                     31, 1'b0, 32'h0BAD_F00D, 3, 1'b0, 32'h0000_0300));
`endif

    // Reset state, with reset asserted.
    #2;
    addr_or = 32'd0;
    for (int i = 0; i < SN; i++) addr_or = addr_or | m_addr[i] | m_wdata[i];
    chk("reset.up", {up_if.ack, up_if.err, up_if.rdata}, 34'd0);
    chk("reset.strobes", {m_wen, m_ren}, 10'd0);
    chk("reset.m_addr_wdata", addr_or, 32'd0);
    @(posedge ACLK); #1;
    ARESETn = 1'b1;

    // Directed table.
    foreach (tbl[n]) begin
      run_txn(tbl[n], o);
      check_txn($sformatf("vec%0d", n), tbl[n], o);
    end

    // Back-to-back: the next request is issued in the cycle the upstream ack is seen.
    up_if.addr = 32'h0030_0000; up_if.ren = 1'b1;
    @(posedge ACLK); #1;
    chk("b2b.strobe_a", {m_wen, m_ren}, {5'b00000, 5'b01000});
    drive_idle();
    s_ack[3] = 1'b1; s_rdata[3] = 32'h0000_0B2B; s_err[3] = 1'b0;
    @(posedge ACLK); #1;
    s_ack = '0;
    chk("b2b.ack_a", {up_if.ack, up_if.err, up_if.rdata}, {1'b1, 1'b0, 32'h0000_0B2B});
    up_if.addr = 32'h0000_0040; up_if.wdata = 32'h0000_0077; up_if.wen = 1'b1;
    @(posedge ACLK); #1;
    chk("b2b.strobe_b", {m_wen, m_ren, up_if.ack}, {5'b00001, 5'b00000, 1'b0});
    chk("b2b.m_wdata_b", m_wdata[0], 32'h0000_0077);
    drive_idle();
    s_ack[0] = 1'b1; s_rdata[0] = 32'h1111_2222; s_err[0] = 1'b0;
    @(posedge ACLK); #1;
    s_ack = '0;
    chk("b2b.ack_b", {up_if.ack, up_if.err, up_if.rdata}, {1'b1, 1'b0, 32'h0});
    @(posedge ACLK); #1;

    // Randomized transactions against the reference model.
    for (int n = 0; n < 150; n++) begin
      v.addr  = $urandom;
      v.wdata = $urandom;
      op      = int'($urandom_range(0, 2));
      v.wen   = (op != 0);
      v.ren   = (op != 1);
      v.k     = int'($urandom_range(1, 20));
      v.srd   = $urandom;
      v.serr  = 1'($urandom_range(0, 1));
      v.noise = 1'($urandom_range(0, 1));
      v = model(v);
      run_txn(v, o);
      check_txn($sformatf("rnd%0d", n), v, o);
    end

    // Leave a non-zero rdata, then reset in mid-PEND.
    run_txn(tbl[0], o);
    check_txn("pre_reset", tbl[0], o);
    up_if.addr = 32'h0010_0020; up_if.ren = 1'b1;
    @(posedge ACLK); #1;
    drive_idle();
    chk("rst.strobe_before", m_ren[1], 1'b1);
    #2 ARESETn = 1'b0;
    #1;
    addr_or = 32'd0;
    for (int i = 0; i < SN; i++) addr_or = addr_or | m_addr[i] | m_wdata[i];
    chk("rst.up_cleared", {up_if.ack, up_if.err, up_if.rdata}, 34'd0);
    chk("rst.strobes_cleared", {m_wen, m_ren}, 10'd0);
    chk("rst.m_addr_cleared", addr_or, 32'd0);
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    s_ack[1] = 1'b1; s_rdata[1] = 32'h9999_9999; s_err[1] = 1'b1;
    acks = 0; strobes = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge ACLK); #1;
      s_ack = '0;
      acks += int'(up_if.ack);
      strobes += $countones(m_wen) + $countones(m_ren);
    end
    chk("rst.late_ack_ignored", acks, 0);
    chk("rst.no_strobe", strobes, 0);
    chk("rst.rdata_still_0", up_if.rdata, 32'd0);
    v = mk(32'h0010_0020, 32'h0, 1'b0, 1'b1, 2, 32'h0F0F_0F0F, 1'b0, 1'b0,
           3, 1'b0, 32'h0F0F_0F0F, 1, 1'b0, 32'h0000_0020);
    run_txn(v, o);
    check_txn("post_reset", v, o);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
